// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//   Shares one SPI master between NUM_REQ requesters. A round-robin grant
//   covers a whole burst of one or more bytes. During the burst the block
//   drives the requester's chip select and the master mode. It sequences
//   the master start handshake for each byte and returns each received byte.
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   req_i           per-requester burst request (level)
//   mode_i          {cpol,cpha} per requester, slice k = [2k+1:2k]
//   tx_data_i       per-requester tx byte, slice k = [k*DATA_WIDTH +: DATA_WIDTH]
//   tx_valid_i      per-requester tx byte valid
//   tx_last_i       marks the tx byte as final byte of the burst
//   tx_ready_o      one-cycle accept pulse to the granted requester
//   gnt_o           one-hot grant, held for the whole burst
//   rx_data_o       received byte (shared bus)
//   rx_valid_o      one-cycle receive pulse to the granted requester
//   cs_n_o          active-low device selects
//   m_start         master start
//   m_cpol, m_cpha  master mode
//   m_data_in       master tx byte
//   m_data_out      master rx byte
//   err_o           WAIT_TX timeout abort pulse
//
// Build option: define SPI_ARB_TIMEOUT_EN to abort a burst after TIMEOUT
// idle cycles in WAIT_TX. Without it WAIT_TX waits forever and err_o is 0.

module spi_txn_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned XFER_CYCLES = 68,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned CS_SETUP    = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [2*NUM_REQ-1:0]          mode_i,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] tx_data_i,
    input  logic [NUM_REQ-1:0]            tx_valid_i,
    input  logic [NUM_REQ-1:0]            tx_last_i,
    output logic [NUM_REQ-1:0]            tx_ready_o,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [DATA_WIDTH-1:0]         rx_data_o,
    output logic [NUM_REQ-1:0]            rx_valid_o,
    output logic [NUM_REQ-1:0]            cs_n_o,
    output logic                          m_start,
    output logic                          m_cpol,
    output logic                          m_cpha,
    output logic [DATA_WIDTH-1:0]         m_data_in,
    input  logic [DATA_WIDTH-1:0]         m_data_out,
    output logic                          err_o
);

    localparam int unsigned IDX_W   = $clog2(NUM_REQ);
    localparam int unsigned CNT_MAX = (XFER_CYCLES > TIMEOUT) ? XFER_CYCLES : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t SETUP_END = cnt_t'(CS_SETUP - 1);
    localparam cnt_t XFER_END  = cnt_t'(XFER_CYCLES - 1);
    localparam cnt_t GAP_END   = cnt_t'(GAP_CYCLES - 1);
`ifdef SPI_ARB_TIMEOUT_EN
    localparam cnt_t TO_END    = cnt_t'(TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_TX,
        XFER,
        GAP,
        RELEASE
    } state_t;

    state_t             state_q, state_d;
    cnt_t               cnt_q, cnt_d;
    logic [IDX_W-1:0]   sel_q;
    logic [IDX_W-1:0]   rr_q;
    logic               last_q;
    logic [IDX_W-1:0]   pick;
    logic               pick_vld;
    logic [NUM_REQ-1:0] sel_oh;
    int unsigned        cand;

    // First requesting index at or after rr_q, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(rr_q) + i) % NUM_REQ;
            if (!pick_vld && req_i[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_oh        = '0;
        sel_oh[sel_q] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        gnt_o      = '0;
        tx_ready_o = '0;
        rx_valid_o = '0;
        m_start    = 1'b0;
        err_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) state_d = SETUP;
            end
            SETUP: begin
                gnt_o = sel_oh;
                if (cnt_q == SETUP_END) state_d = WAIT_TX;
            end
            WAIT_TX: begin
                gnt_o = sel_oh;
                if (tx_valid_i[sel_q]) begin
                    tx_ready_o = sel_oh;
                    state_d    = XFER;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_q == TO_END) begin
                    err_o   = 1'b1;
                    state_d = RELEASE;
                end
`endif
            end
            XFER: begin
                gnt_o   = sel_oh;
                m_start = 1'b1;
                if (cnt_q == XFER_END) state_d = GAP;
            end
            GAP: begin
                gnt_o = sel_oh;
                if (cnt_q == '0) rx_valid_o = sel_oh;
                if (cnt_q == GAP_END) state_d = last_q ? RELEASE : WAIT_TX;
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cs_n_o = ~gnt_o;

    // The counter restarts at zero on every state change.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q) begin
            case (state_q)
                SETUP, XFER, GAP: cnt_d = cnt_q + 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                WAIT_TX:          cnt_d = cnt_q + 1'b1;
`endif
                default:          cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            rr_q      <= '0;
            last_q    <= 1'b0;
            m_cpol    <= 1'b0;
            m_cpha    <= 1'b0;
            m_data_in <= '0;
            rx_data_o <= '0;
        end else begin
            if (state_q == IDLE && pick_vld) begin
                sel_q            <= pick;
                {m_cpol, m_cpha} <= mode_i[2*pick +: 2];
            end
            if (state_q == WAIT_TX && tx_valid_i[sel_q]) begin
                m_data_in <= tx_data_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
                last_q    <= tx_last_i[sel_q];
            end
            if (state_q == XFER && cnt_q == XFER_END) rx_data_o <= m_data_out;
            if (state_q == RELEASE)
                rr_q <= (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter: stimulus pushes expected grants and
// received bytes, a monitor pops and compares when the DUT presents them.
module tb_spi_txn_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned XC = 68;
    localparam int unsigned GC = 2;
    localparam int unsigned CS = 2;
    localparam int unsigned TO = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_i = '0;
    logic [2*NR-1:0]   mode_i = '0;
    logic [DW*NR-1:0]  tx_data_i = '0;
    logic [NR-1:0]     tx_valid_i = '0;
    logic [NR-1:0]     tx_last_i = '0;
    logic [NR-1:0]     tx_ready_o, gnt_o, rx_valid_o, cs_n_o;
    logic [DW-1:0]     rx_data_o, m_data_in, m_data_out;
    logic              m_start, m_cpol, m_cpha, err_o;

    spi_txn_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .XFER_CYCLES(XC),
        .GAP_CYCLES(GC), .CS_SETUP(CS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .mode_i(mode_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_last_i(tx_last_i),
        .tx_ready_o(tx_ready_o), .gnt_o(gnt_o), .rx_data_o(rx_data_o),
        .rx_valid_o(rx_valid_o), .cs_n_o(cs_n_o), .m_start(m_start),
        .m_cpol(m_cpol), .m_cpha(m_cpha), .m_data_in(m_data_in),
        .m_data_out(m_data_out), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Master model: loops data back only on the last cycle of m_start.
    int unsigned mcnt = 0;
    always @(posedge clk) mcnt <= m_start ? mcnt + 1 : 0;
    assign m_data_out = (m_start && mcnt == XC - 1) ? m_data_in : 8'h00;

    typedef struct packed { logic [1:0] idx; logic last; logic [7:0] data; } tx_ent_t;
    typedef struct packed { logic [1:0] idx; logic [7:0] data; } rx_ent_t;

    tx_ent_t    feed_q[$];
    rx_ent_t    exp_rx[$];
    logic [1:0] exp_gnt[$];

    int vectors = 0;
    int miscompares = 0;
    int gnt_events = 0;
    int err_events = 0;
    int tx_cnt[NR] = '{default: 0};
    int rx_cnt[NR] = '{default: 0};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_unexp(string name, logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got 0x%0h, expected nothing", name, act);
    endfunction

    function automatic logic [NR-1:0] onehot(input logic [1:0] k);
        logic [NR-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Requester clients: present the first queued byte of each requester.
    initial begin : feeder
        logic [NR-1:0]    tv, tl;
        logic [DW*NR-1:0] td;
        logic [1:0]       k;
        forever begin
            @(negedge clk);
            if (tx_ready_o != 0 && !rst) begin
                k = '0;
                for (int i = 0; i < NR; i++) if (tx_ready_o[i]) k = 2'(i);
                @(posedge clk);
                #1;
                for (int i = 0; i < feed_q.size(); i++) begin
                    if (feed_q[i].idx == k) begin
                        feed_q.delete(i);
                        break;
                    end
                end
            end
            tv = '0; tl = '0; td = '0;
            for (int i = 0; i < feed_q.size(); i++) begin
                if (!tv[feed_q[i].idx]) begin
                    tv[feed_q[i].idx] = 1'b1;
                    tl[feed_q[i].idx] = feed_q[i].last;
                    td[feed_q[i].idx*DW +: DW] = feed_q[i].data;
                end
            end
            tx_valid_i = tv;
            tx_last_i  = tl;
            tx_data_i  = td;
        end
    end

    initial begin : monitor
        int            run = 0;
        int            low_run = 0;
        int            idle_run = 100;
        bit            seen = 0;
        logic [NR-1:0] prev_gnt = '0;
        logic [NR-1:0] tmp;
        logic [1:0]    eg;
        rx_ent_t       r;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0; low_run = 0; seen = 0; idle_run = 100; prev_gnt = '0;
            end else begin
                tmp = ~gnt_o;
                chk("cs_n_vs_gnt", 32'(cs_n_o), 32'(tmp));
                chk("gnt_onehot", 32'($countones(gnt_o) <= 1), 1);
                tmp = tx_ready_o & ~gnt_o;
                chk("tx_ready_leak", 32'(tmp), 0);
                tmp = rx_valid_o & ~gnt_o;
                chk("rx_valid_leak", 32'(tmp), 0);
`ifdef SPI_ARB_TIMEOUT_EN
                if (err_o) err_events++;
`else
                chk("err_tied", 32'(err_o), 0);
`endif
                if (gnt_o != 0 && prev_gnt == 0) begin
                    gnt_events++;
                    chk("cs_high_between", 32'(idle_run >= 2), 1);
                    if (exp_gnt.size() == 0) fail_unexp("gnt_unexpected", 32'(gnt_o));
                    else begin
                        eg = exp_gnt.pop_front();
                        chk("gnt_order", 32'(gnt_o), 32'(onehot(eg)));
                    end
                end else if (gnt_o != 0 && gnt_o != prev_gnt) begin
                    chk("gnt_stable", 32'(gnt_o), 32'(prev_gnt));
                end
                idle_run = (gnt_o == 0) ? idle_run + 1 : 0;
                prev_gnt = gnt_o;
                for (int i = 0; i < NR; i++) begin
                    if (tx_ready_o[i]) tx_cnt[i]++;
                    if (rx_valid_o[i]) rx_cnt[i]++;
                end
                if (rx_valid_o != 0) begin
                    if (exp_rx.size() == 0) fail_unexp("rx_unexpected", 32'(rx_data_o));
                    else begin
                        r = exp_rx.pop_front();
                        chk("rx_valid_sel", 32'(rx_valid_o), 32'(onehot(r.idx)));
                        chk("rx_data", 32'(rx_data_o), 32'(r.data));
                    end
                end
                if (m_start) begin
                    if (low_run > 0 && seen) chk("byte_gap", low_run, 1 + GC);
                    low_run = 0;
                    seen = 1;
                    run++;
                end else begin
                    if (run > 0) chk("m_start_len", run, XC);
                    run = 0;
                    if (gnt_o == 0) begin
                        seen = 0;
                        low_run = 0;
                    end else if (seen) low_run++;
                end
            end
        end
    end

    task automatic push_tx(input logic [1:0] k, input logic last, input logic [7:0] d);
        tx_ent_t t;
        rx_ent_t r;
        t.idx = k; t.last = last; t.data = d;
        feed_q.push_back(t);
        r.idx = k; r.data = d;
        exp_rx.push_back(r);
    endtask

    task automatic wait_gnts(input string name, input int target);
        int n = 0;
        while (gnt_events < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(gnt_events >= target), 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(feed_q.size() == 0 && exp_rx.size() == 0 && gnt_o == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(feed_q.size() == 0 && exp_rx.size() == 0 && gnt_o == 0), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int base, t0, r0, n;
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_cs_n", 32'(cs_n_o), 32'hF);
        chk("rst_tx_ready", 32'(tx_ready_o), 0);
        chk("rst_rx_valid", 32'(rx_valid_o), 0);
        chk("rst_rx_data", 32'(rx_data_o), 0);
        chk("rst_m_start", 32'(m_start), 0);
        chk("rst_mode", 32'({m_cpol, m_cpha}), 0);
        chk("rst_m_data_in", 32'(m_data_in), 0);
        chk("rst_err", 32'(err_o), 0);
        rst = 1'b0;

        // Single byte 0xA5 on requester 0, timing of cs_n to m_start
        push_tx(2'd0, 1'b1, 8'hA5);
        exp_gnt.push_back(2'd0);
        repeat (2) @(negedge clk);
        mode_i = 8'h00;
        req_i = 4'b0001;
        @(negedge clk);
        chk("t1_gnt", 32'(gnt_o), 32'h1);
        chk("t1_cs_n", 32'(cs_n_o), 32'hE);
        req_i = '0;
        @(negedge clk);
        chk("t1_start_setup", 32'(m_start), 0);
        @(negedge clk);
        chk("t1_start_wait", 32'(m_start), 0);
        chk("t1_tx_ready", 32'(tx_ready_o), 32'h1);
        @(negedge clk);
        chk("t1_start_rise", 32'(m_start), 1);
        chk("t1_m_data_in", 32'(m_data_in), 32'hA5);
        wait_done("t1_done");
        chk("t1_rx_data_hold", 32'(rx_data_o), 32'hA5);
        chk("t1_cs_released", 32'(cs_n_o), 32'hF);

        // Round robin with all four requesting
        do_reset();
        base = gnt_events;
        push_tx(2'd0, 1'b1, 8'h10);
        push_tx(2'd1, 1'b1, 8'h21);
        push_tx(2'd2, 1'b1, 8'h32);
        push_tx(2'd3, 1'b1, 8'h43);
        push_tx(2'd0, 1'b1, 8'h54);
        exp_gnt.push_back(2'd0); exp_gnt.push_back(2'd1); exp_gnt.push_back(2'd2);
        exp_gnt.push_back(2'd3); exp_gnt.push_back(2'd0);
        repeat (2) @(negedge clk);
        req_i = 4'b1111;
        wait_gnts("t2_grants", base + 5);
        req_i = '0;
        wait_done("t2_done");

        // Three-byte burst on requester 2, mode 11, mode change ignored
        base = gnt_events; t0 = tx_cnt[2]; r0 = rx_cnt[2];
        push_tx(2'd2, 1'b0, 8'h11);
        push_tx(2'd2, 1'b0, 8'h22);
        push_tx(2'd2, 1'b1, 8'h33);
        exp_gnt.push_back(2'd2);
        repeat (2) @(negedge clk);
        mode_i = 8'b00_11_00_00;
        req_i = 4'b0100;
        wait_gnts("t3_grant", base + 1);
        req_i = '0;
        mode_i = '0;
        repeat (100) @(negedge clk);
        chk("t3_mode_held", 32'({m_cpol, m_cpha}), 32'h3);
        chk("t3_cs_n_mid", 32'(cs_n_o), 32'hB);
        wait_done("t3_done");
        chk("t3_tx_ready_count", tx_cnt[2] - t0, 3);
        chk("t3_rx_valid_count", rx_cnt[2] - r0, 3);

        // Reset 20 cycles into XFER; rr pointer returns to 0
        base = gnt_events;
        feed_q.push_back('{idx: 2'd1, last: 1'b1, data: 8'h77});
        exp_gnt.push_back(2'd1);
        repeat (2) @(negedge clk);
        req_i = 4'b0010;
        wait_gnts("t4_grant", base + 1);
        req_i = '0;
        n = 0;
        while (!m_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_xfer_reached", 32'(m_start), 1);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_m_start", 32'(m_start), 0);
        chk("t4_cs_n", 32'(cs_n_o), 32'hF);
        chk("t4_gnt", 32'(gnt_o), 0);
        chk("t4_m_data_in", 32'(m_data_in), 0);
        @(negedge clk);
        rst = 1'b0;
        base = gnt_events;
        push_tx(2'd0, 1'b1, 8'h01);
        push_tx(2'd3, 1'b1, 8'h03);
        exp_gnt.push_back(2'd0); exp_gnt.push_back(2'd3);
        repeat (2) @(negedge clk);
        req_i = 4'b1001;
        wait_gnts("t4_regrant", base + 2);
        req_i = '0;
        wait_done("t4_done");

        // Requester 1 drops req after grant; burst runs to the last byte
        base = gnt_events; t0 = tx_cnt[1];
        push_tx(2'd1, 1'b0, 8'h5A);
        push_tx(2'd1, 1'b1, 8'hC3);
        exp_gnt.push_back(2'd1);
        repeat (2) @(negedge clk);
        mode_i = 8'b00_00_10_00;
        req_i = 4'b0010;
        wait_gnts("t5_grant", base + 1);
        req_i = '0;
        wait_done("t5_done");
        chk("t5_tx_ready_count", tx_cnt[1] - t0, 2);
        chk("t5_mode", 32'({m_cpol, m_cpha}), 32'h2);

`ifdef SPI_ARB_TIMEOUT_EN
        // Requester 3 never offers data: abort after TIMEOUT WAIT_TX cycles
        base = gnt_events; t0 = err_events; r0 = rx_cnt[3];
        push_tx(2'd0, 1'b1, 8'h99);
        exp_gnt.push_back(2'd3); exp_gnt.push_back(2'd0);
        repeat (2) @(negedge clk);
        req_i = 4'b1001;
        wait_gnts("to_grant3", base + 1);
        n = 0;
        while (!err_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("to_err_cycle", n, CS + TO - 1);
        wait_gnts("to_grant0", base + 2);
        req_i = '0;
        wait_done("to_done");
        chk("to_err_count", err_events - t0, 1);
        chk("to_no_rx3", rx_cnt[3] - r0, 0);
`endif

        chk("gnt_queue_empty", 32'(exp_gnt.size()), 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
